e_ppn_limb_addsub_sm: RTL and testbench

Parametrised, limb-serial signed-magnitude adder/subtractor and successor of the fixed 256-bit add/sub wrapper. It accepts operands as magnitude plus sign, derives the effective operation, and walks one LIMB_W slice per cycle through a single limb adder. When an effective subtract borrows, a second negate pass produces a proper sign-magnitude result. It sits between the ECDSA point-arithmetic sequencer and the modular units, and uses a valid/ready handshake on both sides.

---
 rtl/e_ppn_arith_pkg.sv | 22 ++
 rtl/e_ppn_limb_add.sv | 16 +
 rtl/e_ppn_limb_addsub_sm.sv | 249 ++++++++++++++++++++++++
 tb/tb_e_ppn_limb_addsub_sm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e_ppn_arith_pkg.sv
// Shared encodings and helpers for the limb-serial e_ppn arithmetic units.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package e_ppn_arith_pkg;

    // Sequencer states (3-bit encoding kept for legacy tooling)
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CAL  = 3'd1;
    localparam logic [2:0] S_NEG  = 3'd2;
    localparam logic [2:0] S_RED  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Requested operation on the magnitudes
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of limb cycles needed to walk a full operand
    function automatic int limb_count(input int width, input int limb_w);
        return width / limb_w;
    endfunction

endpackage

// File: rtl/e_ppn_limb_add.sv
// Combinational LIMB_W-bit adder with carry in/out, shared by all limb passes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent sequences operands and holds the carry.
module e_ppn_limb_add #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              c_i,
    output logic [LIMB_W-1:0] s,
    output logic              c_o
);

    assign {c_o, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, c_i};

endmodule

// File: rtl/e_ppn_limb_addsub_sm.sv
// Limb-serial signed-magnitude add/sub; optional trial mod reduction under `ADDSUB_MOD_EN`.
// Latency: NLIMB+1 cycles accept->out_valid; 2*NLIMB+1 when a NEG or RED pass runs.
// Backpressure: result held in DONE until out_ready; new bundle accepted in IDLE or as DONE drains.
module e_ppn_limb_addsub_sm
    import e_ppn_arith_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int LIMB_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             sign_a,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sign_b,
`ifdef ADDSUB_MOD_EN
    input  logic [WIDTH-1:0] mod_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_o,
    output logic             sign_o,
    output logic             ovf_o
);

    localparam int NLIMB = limb_count(WIDTH, LIMB_W);
    localparam int LW    = $clog2(NLIMB + 1);
    localparam logic [LW-1:0] LIMB_LAST   = LW'(NLIMB - 1);
    // One extra CAL step reads the registered final carry to pick the next pass
    localparam logic [LW-1:0] LIMB_SETTLE = LW'(NLIMB);

    if (WIDTH % LIMB_W != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of LIMB_W");
    end

    logic [2:0]       state_q, state_d;
    logic [LW-1:0]    limb_q, limb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic             eff_sub_q, eff_sub_d, sign_a_q, sign_a_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sign_q, sign_d, ovf_q, ovf_d;
`ifdef ADDSUB_MOD_EN
    logic [WIDTH-1:0] mod_q, mod_d, t_q, t_d;
    logic             cout_q, cout_d;
`endif

    logic [LIMB_W-1:0] add_x, add_y, add_s;
    logic              add_c, add_co;
    logic              first, last_limb, settle;
    int                lsb;
    logic              fin_load, fin_sign, fin_ovf;
    logic [WIDTH-1:0]  fin_mag;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid = (state_q == S_DONE);
    assign data_o    = data_q;
    assign sign_o    = sign_q;
    assign ovf_o     = ovf_q;

    assign first     = (limb_q == '0);
    assign last_limb = (limb_q == LIMB_LAST);
    assign settle    = (limb_q == LIMB_SETTLE);
    assign lsb       = settle ? 0 : int'(limb_q) * LIMB_W;

    e_ppn_limb_add #(.LIMB_W(LIMB_W)) u_add (
        .a   (add_x),
        .b   (add_y),
        .c_i (add_c),
        .s   (add_s),
        .c_o (add_co)
    );

    // Operand mux: route the current limb of the active pass into the shared adder
    always_comb begin
        add_x = '0;
        add_y = '0;
        add_c = 1'b0;
        case (state_q)
            S_CAL: begin
                add_x = a_q[lsb +: LIMB_W];
                add_y = eff_sub_q ? ~b_q[lsb +: LIMB_W] : b_q[lsb +: LIMB_W];
                add_c = first ? eff_sub_q : carry_q;
            end
            S_NEG: begin
                add_x = ~r_q[lsb +: LIMB_W];
                add_c = first ? 1'b1 : carry_q;
            end
`ifdef ADDSUB_MOD_EN
            S_RED: begin
                add_x = r_q[lsb +: LIMB_W];
                add_y = ~mod_q[lsb +: LIMB_W];
                add_c = first ? 1'b1 : carry_q;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: limb stepping, pass selection, result capture and accept
    always_comb begin
        state_d   = state_q;
        limb_d    = limb_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        eff_sub_d = eff_sub_q;
        sign_a_d  = sign_a_q;
        data_d    = data_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
`ifdef ADDSUB_MOD_EN
        mod_d     = mod_q;
        t_d       = t_q;
        cout_d    = cout_q;
`endif
        fin_load  = 1'b0;
        fin_mag   = '0;
        fin_sign  = 1'b0;
        fin_ovf   = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_CAL: begin
                if (!settle) begin
                    r_d[lsb +: LIMB_W] = add_s;
                    carry_d = add_co;
                    limb_d  = limb_q + 1'b1;
                end else begin
                    limb_d  = '0;
                    carry_d = 1'b0;
                    if (eff_sub_q && !carry_q) begin
                        // a < b: magnitude is in two's complement, negate it
                        state_d = S_NEG;
                    end else if (eff_sub_q) begin
                        fin_load = 1'b1;
                        fin_mag  = r_q;
                        fin_sign = sign_a_q;
                    end else begin
`ifdef ADDSUB_MOD_EN
                        cout_d  = carry_q;
                        state_d = S_RED;
`else
                        fin_load = 1'b1;
                        fin_mag  = r_q;
                        fin_sign = sign_a_q;
                        fin_ovf  = carry_q;
`endif
                    end
                end
            end
            S_NEG: begin
                r_d[lsb +: LIMB_W] = add_s;
                carry_d = add_co;
                limb_d  = limb_q + 1'b1;
                if (last_limb) begin
                    limb_d   = '0;
                    carry_d  = 1'b0;
                    fin_load = 1'b1;
                    fin_mag  = r_d;
                    fin_sign = ~sign_a_q;
                end
            end
`ifdef ADDSUB_MOD_EN
            S_RED: begin
                t_d[lsb +: LIMB_W] = add_s;
                carry_d = add_co;
                limb_d  = limb_q + 1'b1;
                if (last_limb) begin
                    limb_d   = '0;
                    carry_d  = 1'b0;
                    fin_load = 1'b1;
                    // Keep r-mod when the sum overflowed or the trial did not borrow
                    fin_mag  = (cout_q | add_co) ? t_d : r_q;
                    fin_sign = sign_a_q;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin_load) begin
            state_d = S_DONE;
            data_d  = fin_mag;
            sign_d  = (fin_mag == '0) ? 1'b0 : fin_sign;
            ovf_d   = fin_ovf;
        end

        if (in_valid && in_ready) begin
            state_d   = S_CAL;
            limb_d    = '0;
            carry_d   = 1'b0;
            a_d       = a_i;
            b_d       = b_i;
            eff_sub_d = op_i ^ sign_a ^ sign_b;
            sign_a_d  = sign_a;
`ifdef ADDSUB_MOD_EN
            mod_d     = mod_i;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            limb_q    <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            eff_sub_q <= 1'b0;
            sign_a_q  <= 1'b0;
            data_q    <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ADDSUB_MOD_EN
            mod_q     <= '0;
            t_q       <= '0;
            cout_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            limb_q    <= limb_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            eff_sub_q <= eff_sub_d;
            sign_a_q  <= sign_a_d;
            data_q    <= data_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
`ifdef ADDSUB_MOD_EN
            mod_q     <= mod_d;
            t_q       <= t_d;
            cout_q    <= cout_d;
`endif
        end
    end

endmodule

// File: tb/tb_e_ppn_limb_addsub_sm.sv
// Bench for e_ppn_limb_addsub_sm: scoreboard of modelled results, popped on each output handshake.
// Latency: checked per result against NLIMB+1 / 2*NLIMB+1.
// Backpressure: exercises output stall, back-to-back accept and mid-operation reset.
module tb_e_ppn_limb_addsub_sm;

    localparam int W  = 256;
    localparam int NL = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         sign;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, op_i, sign_a, sign_b;
    logic [W-1:0] a_i, b_i, mod_v;
    logic         out_valid, out_ready, sign_o, ovf_o;
    logic [W-1:0] data_o;

    int   n_tot = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    logic seen = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    e_ppn_limb_addsub_sm dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .a_i       (a_i),
        .sign_a    (sign_a),
        .b_i       (b_i),
        .sign_b    (sign_b),
`ifdef ADDSUB_MOD_EN
        .mod_i     (mod_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .sign_o    (sign_o),
        .ovf_o     (ovf_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the magnitudes
    function automatic exp_t model(input logic [W-1:0] a, input logic sa, input logic [W-1:0] b,
                                   input logic sb_, input logic op, input logic [W-1:0] m);
        exp_t e;
        logic [W:0] sum;
        e.acc = 0;
        if (!(op ^ sa ^ sb_)) begin
            sum    = {1'b0, a} + {1'b0, b};
            e.data = sum[W-1:0];
            e.ovf  = sum[W];
            e.sign = sa;
            e.lat  = NL + 1;
`ifdef ADDSUB_MOD_EN
            if (sum >= {1'b0, m}) begin
                sum    = sum - {1'b0, m};
                e.data = sum[W-1:0];
            end
            e.ovf = 1'b0;
            e.lat = 2 * NL + 1;
`else
            if (m == '1) e.lat = NL + 1;
`endif
        end else if (a >= b) begin
            e.data = a - b;
            e.sign = sa;
            e.ovf  = 1'b0;
            e.lat  = NL + 1;
        end else begin
            e.data = b - a;
            e.sign = ~sa;
            e.ovf  = 1'b0;
            e.lat  = 2 * NL + 1;
        end
        if (e.data == '0) e.sign = 1'b0;
        return e;
    endfunction

    // Monitor: push on accept, pop and compare on result handshake
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", W'(sb.size() != 0), W'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", data_o, e.data);
                    chk("sign", W'(sign_o), W'(e.sign));
                    chk("ovf", W'(ovf_o), W'(e.ovf));
                    chk("latency", W'(first_cyc - e.acc), W'(e.lat));
                end
                seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(a_i, sign_a, b_i, sign_b, op_i, mod_v);
                e.acc = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic sa, input logic [W-1:0] b,
                         input logic sb_, input logic op);
        a_i = a; sign_a = sa; b_i = b; sign_b = sb_; op_i = op;
    endtask

    task automatic send(input logic [W-1:0] a, input logic sa, input logic [W-1:0] b,
                        input logic sb_, input logic op);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive(a, sa, b, sb_, op);
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("accept_timeout", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_vld();
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        if (!out_valid) chk("valid_timeout", W'(out_valid), W'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", W'(sb.size()), W'(0));
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 2) == 0) v = W'($urandom_range(0, 20));
        return v;
    endfunction

    initial begin
        logic [W-1:0] all1, cap_d;
        logic         cap_s, cap_o;
        all1 = '1;
        mod_v = all1 - W'(188);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_data", data_o, '0);
        chk("rst_sign_ovf", W'({sign_o, ovf_o}), W'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        send(W'(5), 1'b0, W'(3), 1'b0, 1'b1);
        send(W'(3), 1'b0, W'(5), 1'b0, 1'b1);
        send(all1, 1'b0, W'(1), 1'b0, 1'b0);
        send(W'(7), 1'b1, W'(7), 1'b0, 1'b0);
        send(W'(7), 1'b1, W'(9), 1'b1, 1'b1);
        wait_drain();

        // Output stall then back-to-back accept on the draining cycle
        out_ready = 1'b0;
        send(W'(100), 1'b1, W'(40), 1'b0, 1'b0);
        wait_vld();
        cap_d = data_o; cap_s = sign_o; cap_o = ovf_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_data", data_o, cap_d);
            chk("hold_flags", W'({sign_o, ovf_o}), W'({cap_s, cap_o}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(W'(10), 1'b0, W'(20), 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset during CAL limb 2 aborts the operation
        send(W'(11), 1'b0, W'(12), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", W'(out_valid), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_data", data_o, '0);
        chk("abort_flags", W'({sign_o, ovf_o}), W'(0));
        send(W'(1), 1'b0, W'(1), 1'b0, 1'b0);
        wait_drain();

`ifdef ADDSUB_MOD_EN
        send(mod_v - W'(1), 1'b0, W'(2), 1'b0, 1'b0);
        wait_drain();
`endif

        for (int i = 0; i < 16; i++)
            send(rnd(), 1'($urandom), rnd(), 1'($urandom), 1'($urandom));
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

endmodule
